// File: rtl/ctrl_alu_sched_pkg.sv
// ctrl_alu_sched_pkg -- shared execute-side definitions for the control-ALU scheduler.
//   * SIZE_* datapath widths and the execution-flag width
//   * control opcodes understood by the control ALU
//   * scheduler state encoding (RUN / RECOVER)
//   * S1 (issue) and S2 (result) packet structs
//   * branch_target(): pc-relative target with delay slot (pc + 8 + immd*4)
// No ports (package).
package ctrl_alu_sched_pkg;

  localparam int SIZE_DATA           = 32;
  localparam int SIZE_PC             = 32;
  localparam int SIZE_IMMEDIATE      = 16;
  localparam int SIZE_OPCODE_I       = 8;
  localparam int SIZE_ACTIVELIST_LOG = 7;
  localparam int EXECUTION_FLAGS     = 6;

  localparam logic [SIZE_OPCODE_I-1:0] OP_J    = 8'h02;
  localparam logic [SIZE_OPCODE_I-1:0] OP_JAL  = 8'h03;
  localparam logic [SIZE_OPCODE_I-1:0] OP_BEQ  = 8'h04;
  localparam logic [SIZE_OPCODE_I-1:0] OP_BNE  = 8'h05;
  localparam logic [SIZE_OPCODE_I-1:0] OP_JR   = 8'h08;
  localparam logic [SIZE_OPCODE_I-1:0] OP_BC1F = 8'h10;
  localparam logic [SIZE_OPCODE_I-1:0] OP_BC1T = 8'h11;

  // Execution flag bit positions
  localparam int FLAG_MISPRED = 0;  // resolved outcome differs from prediction
  localparam int FLAG_KNOWN   = 1;  // opcode decoded as a control op
  localparam int FLAG_TAKEN   = 2;  // resolved direction
  localparam int FLAG_LINK    = 3;  // op writes the link value
  localparam int FLAG_FPBR    = 4;  // FP-condition branch, resolved elsewhere

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [SIZE_DATA-1:0]           data1;
    logic [SIZE_DATA-1:0]           data2;
    logic [SIZE_IMMEDIATE-1:0]      immd;
    logic [SIZE_OPCODE_I-1:0]       opcode;
    logic [SIZE_PC-1:0]             pc;
    logic [SIZE_PC-1:0]             pred_target;
    logic                           pred_dir;
    logic [SIZE_ACTIVELIST_LOG-1:0] tag;
  } s1_pkt_t;

  typedef struct packed {
    logic [SIZE_PC-1:0]             result;
    logic [SIZE_PC-1:0]             next_pc;
    logic                           direction;
    logic [EXECUTION_FLAGS-1:0]     flags;
    logic [SIZE_ACTIVELIST_LOG-1:0] tag;
  } s2_pkt_t;

  function automatic logic [SIZE_PC-1:0] branch_target(
    input logic [SIZE_PC-1:0]        pc,
    input logic [SIZE_IMMEDIATE-1:0] immd
  );
    logic [SIZE_PC-1:0] offset;
    offset = {{(SIZE_PC-SIZE_IMMEDIATE-2){immd[SIZE_IMMEDIATE-1]}}, immd, 2'b00};
    return pc + SIZE_PC'(8) + offset;
  endfunction

endpackage

// File: rtl/ctrl_alu_sched_alu.sv
// ctrl_alu_sched_alu -- combinational control ALU (branches and jumps).
// Ports:
//   data1, data2  in  operands (data1 is the JR target)
//   immd          in  branch offset in words
//   opcode        in  control opcode
//   pc            in  op pc
//   pred_target   in  predicted target
//   pred_dir      in  predicted direction
//   result        out link value (pc + 8)
//   next_pc       out resolved next pc
//   direction     out resolved direction
//   flags         out execution flags (bit layout in ctrl_alu_sched_pkg)
module ctrl_alu_sched_alu
  import ctrl_alu_sched_pkg::*;
(
  input  logic [SIZE_DATA-1:0]       data1,
  input  logic [SIZE_DATA-1:0]       data2,
  input  logic [SIZE_IMMEDIATE-1:0]  immd,
  input  logic [SIZE_OPCODE_I-1:0]   opcode,
  input  logic [SIZE_PC-1:0]         pc,
  input  logic [SIZE_PC-1:0]         pred_target,
  input  logic                       pred_dir,
  output logic [SIZE_PC-1:0]         result,
  output logic [SIZE_PC-1:0]         next_pc,
  output logic                       direction,
  output logic [EXECUTION_FLAGS-1:0] flags
);

  logic               taken;
  logic               known;
  logic               link;
  logic               fp_branch;
  logic [SIZE_PC-1:0] target;
  logic               mispred;

  always_comb begin
    taken     = 1'b0;
    known     = 1'b1;
    link      = 1'b0;
    fp_branch = 1'b0;
    target    = branch_target(pc, immd);
    case (opcode)
      OP_J:    taken = 1'b1;
      OP_JAL:  begin taken = 1'b1; link = 1'b1; end
      OP_JR:   begin taken = 1'b1; target = data1[SIZE_PC-1:0]; end
      OP_BEQ:  taken = (data1 == data2);
      OP_BNE:  taken = (data1 != data2);
      // FP condition is not visible here: keep the prediction, never mispredict
      OP_BC1F, OP_BC1T: begin
        fp_branch = 1'b1;
        taken     = pred_dir;
        target    = pred_target;
      end
      default: known = 1'b0;
    endcase
    mispred = !fp_branch &&
              ((taken != pred_dir) || (taken && (target != pred_target)));
  end

  assign result    = pc + SIZE_PC'(8);
  assign next_pc   = taken ? target : pc + SIZE_PC'(8);
  assign direction = taken;

  always_comb begin
    flags               = '0;
    flags[FLAG_MISPRED] = mispred;
    flags[FLAG_KNOWN]   = known;
    flags[FLAG_TAKEN]   = taken;
    flags[FLAG_LINK]    = link;
    flags[FLAG_FPBR]    = fp_branch;
  end

endmodule

// File: rtl/ctrl_alu_sched.sv
// ctrl_alu_sched -- two-lane round-robin issue into a two-stage control ALU
// pipeline (S1 issue register -> control ALU -> S2 result register) with
// mispredict redirect, stage-1 squash and a fixed recovery window.
// Optional feature: define CTRL_SCHED_STATS_EN to add saturating 32-bit
// counters stat_branches_o (S2 loads) and stat_mispred_o (redirects).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   flush_i                      pipeline flush from commit (highest priority)
//   reqN_valid_i / reqN_ready_o  lane handshake, N = 0,1
//   reqN_data1_i/_data2_i/_immd_i/_opcode_i/_pc_i/_predTarget_i/_predDir_i/_tag_i
//                                lane op fields
//   out_valid_o / out_ready_i    result handshake
//   out_result_o, out_nextPC_o, out_direction_o, out_flags_o, out_tag_o
//   redirect_valid_o, redirect_pc_o   one-cycle fetch redirect
//   squash_valid_o, squash_tag_o      one-cycle notice of a dropped S1 op
module ctrl_alu_sched
  import ctrl_alu_sched_pkg::*;
#(
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush_i,
  input  logic                           req0_valid_i,
  input  logic                           req1_valid_i,
  output logic                           req0_ready_o,
  output logic                           req1_ready_o,
  input  logic [SIZE_DATA-1:0]           req0_data1_i,
  input  logic [SIZE_DATA-1:0]           req0_data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]      req0_immd_i,
  input  logic [SIZE_OPCODE_I-1:0]       req0_opcode_i,
  input  logic [SIZE_PC-1:0]             req0_pc_i,
  input  logic [SIZE_PC-1:0]             req0_predTarget_i,
  input  logic                           req0_predDir_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] req0_tag_i,
  input  logic [SIZE_DATA-1:0]           req1_data1_i,
  input  logic [SIZE_DATA-1:0]           req1_data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]      req1_immd_i,
  input  logic [SIZE_OPCODE_I-1:0]       req1_opcode_i,
  input  logic [SIZE_PC-1:0]             req1_pc_i,
  input  logic [SIZE_PC-1:0]             req1_predTarget_i,
  input  logic                           req1_predDir_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] req1_tag_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [SIZE_PC-1:0]             out_result_o,
  output logic [SIZE_PC-1:0]             out_nextPC_o,
  output logic                           out_direction_o,
  output logic [EXECUTION_FLAGS-1:0]     out_flags_o,
  output logic [SIZE_ACTIVELIST_LOG-1:0] out_tag_o,
  output logic                           redirect_valid_o,
  output logic [SIZE_PC-1:0]             redirect_pc_o,
  output logic                           squash_valid_o,
  output logic [SIZE_ACTIVELIST_LOG-1:0] squash_tag_o
`ifdef CTRL_SCHED_STATS_EN
  ,
  output logic [31:0]                    stat_branches_o,
  output logic [31:0]                    stat_mispred_o
`endif
);

  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  sched_state_e state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic         rr_reg;

  logic    s1_valid_reg;
  s1_pkt_t s1_pkt_reg;
  logic    s2_valid_reg;
  s2_pkt_t s2_pkt_reg;

  logic                           redirect_valid_reg;
  logic [SIZE_PC-1:0]             redirect_pc_reg;
  logic                           squash_valid_reg;
  logic [SIZE_ACTIVELIST_LOG-1:0] squash_tag_reg;

  s1_pkt_t lane0_pkt, lane1_pkt, issue_pkt;
  s2_pkt_t alu_pkt;
  logic    s1_adv_ok, s1_free, issue_ok;
  logic    gnt0, gnt1, accept;
  logic    s2_load, mispred_load;

  assign lane0_pkt = '{req0_data1_i, req0_data2_i, req0_immd_i, req0_opcode_i,
                       req0_pc_i, req0_predTarget_i, req0_predDir_i, req0_tag_i};
  assign lane1_pkt = '{req1_data1_i, req1_data2_i, req1_immd_i, req1_opcode_i,
                       req1_pc_i, req1_predTarget_i, req1_predDir_i, req1_tag_i};

  // S1 may move on when S2 is empty or S2 is being consumed this cycle
  assign s1_adv_ok = !s2_valid_reg || out_ready_i;
  assign s1_free   = !s1_valid_reg || s1_adv_ok;
  assign issue_ok  = (state_reg == RUN) && !flush_i && s1_free;

  // rr names the preferred lane; a lone requester wins regardless
  assign gnt1 = req1_valid_i && (!req0_valid_i || rr_reg);
  assign gnt0 = req0_valid_i && !gnt1;

  assign req0_ready_o = issue_ok && gnt0;
  assign req1_ready_o = issue_ok && gnt1;
  assign accept       = req0_ready_o || req1_ready_o;
  assign issue_pkt    = gnt1 ? lane1_pkt : lane0_pkt;

  ctrl_alu_sched_alu u_alu (
    .data1       (s1_pkt_reg.data1),
    .data2       (s1_pkt_reg.data2),
    .immd        (s1_pkt_reg.immd),
    .opcode      (s1_pkt_reg.opcode),
    .pc          (s1_pkt_reg.pc),
    .pred_target (s1_pkt_reg.pred_target),
    .pred_dir    (s1_pkt_reg.pred_dir),
    .result      (alu_pkt.result),
    .next_pc     (alu_pkt.next_pc),
    .direction   (alu_pkt.direction),
    .flags       (alu_pkt.flags)
  );
  assign alu_pkt.tag = s1_pkt_reg.tag;

  assign s2_load      = s1_valid_reg && s1_adv_ok && !flush_i;
  assign mispred_load = s2_load && alu_pkt.flags[FLAG_MISPRED];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush_i) begin
      state_next = RUN;
      cnt_next   = '0;
    end else if (mispred_load) begin
      state_next = RECOVER;
      cnt_next   = RECOVER_LOAD;
    end else if (state_reg == RECOVER) begin
      if (cnt_reg == '0) state_next = RUN;
      else               cnt_next   = cnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_reg             <= 1'b0;
      s1_valid_reg       <= 1'b0;
      s1_pkt_reg         <= '0;
      s2_valid_reg       <= 1'b0;
      s2_pkt_reg         <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      squash_valid_reg   <= 1'b0;
      squash_tag_reg     <= '0;
    end else begin
      if (accept) rr_reg <= req0_ready_o;

      // The op accepted alongside a mispredicting S2 load is younger than the
      // branch: drop it instead of letting it enter S1, and report it.
      if (flush_i || mispred_load) begin
        s1_valid_reg <= 1'b0;
      end else if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_pkt_reg   <= issue_pkt;
      end else if (s1_adv_ok) begin
        s1_valid_reg <= 1'b0;
      end

      if (flush_i) begin
        s2_valid_reg <= 1'b0;
      end else if (s1_adv_ok) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) s2_pkt_reg <= alu_pkt;
      end

      redirect_valid_reg <= mispred_load;
      if (mispred_load) redirect_pc_reg <= alu_pkt.next_pc;
      squash_valid_reg <= mispred_load && accept;
      if (mispred_load && accept) squash_tag_reg <= issue_pkt.tag;
    end
  end

  assign out_valid_o      = s2_valid_reg;
  assign out_result_o     = s2_pkt_reg.result;
  assign out_nextPC_o     = s2_pkt_reg.next_pc;
  assign out_direction_o  = s2_pkt_reg.direction;
  assign out_flags_o      = s2_pkt_reg.flags;
  assign out_tag_o        = s2_pkt_reg.tag;
  assign redirect_valid_o = redirect_valid_reg;
  assign redirect_pc_o    = redirect_pc_reg;
  assign squash_valid_o   = squash_valid_reg;
  assign squash_tag_o     = squash_tag_reg;

`ifdef CTRL_SCHED_STATS_EN
  logic [31:0] stat_branches_reg, stat_mispred_reg;

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_reg <= '0;
      stat_mispred_reg  <= '0;
    end else begin
      if (s2_load && (stat_branches_reg != '1))
        stat_branches_reg <= stat_branches_reg + 32'd1;
      if (mispred_load && (stat_mispred_reg != '1))
        stat_mispred_reg <= stat_mispred_reg + 32'd1;
    end
  end

  assign stat_branches_o = stat_branches_reg;
  assign stat_mispred_o  = stat_mispred_reg;
`endif

endmodule

// File: tb/tb_ctrl_alu_sched.sv
module tb_ctrl_alu_sched;
  import ctrl_alu_sched_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush_i;
  logic req0_valid_i, req1_valid_i;
  logic req0_ready_o, req1_ready_o;
  logic [SIZE_DATA-1:0]           req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
  logic [SIZE_IMMEDIATE-1:0]      req0_immd_i, req1_immd_i;
  logic [SIZE_OPCODE_I-1:0]       req0_opcode_i, req1_opcode_i;
  logic [SIZE_PC-1:0]             req0_pc_i, req0_predTarget_i, req1_pc_i, req1_predTarget_i;
  logic                           req0_predDir_i, req1_predDir_i;
  logic [SIZE_ACTIVELIST_LOG-1:0] req0_tag_i, req1_tag_i;
  logic                           out_valid_o, out_ready_i;
  logic [SIZE_PC-1:0]             out_result_o, out_nextPC_o;
  logic                           out_direction_o;
  logic [EXECUTION_FLAGS-1:0]     out_flags_o;
  logic [SIZE_ACTIVELIST_LOG-1:0] out_tag_o;
  logic                           redirect_valid_o;
  logic [SIZE_PC-1:0]             redirect_pc_o;
  logic                           squash_valid_o;
  logic [SIZE_ACTIVELIST_LOG-1:0] squash_tag_o;
`ifdef CTRL_SCHED_STATS_EN
  logic [31:0] stat_branches_o, stat_mispred_o;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  logic seen7 = 1'b0;

  always #5 clk = ~clk;

  ctrl_alu_sched #(.RECOVER_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req1_valid_i(req1_valid_i),
    .req0_ready_o(req0_ready_o), .req1_ready_o(req1_ready_o),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
    .req0_immd_i(req0_immd_i), .req0_opcode_i(req0_opcode_i),
    .req0_pc_i(req0_pc_i), .req0_predTarget_i(req0_predTarget_i),
    .req0_predDir_i(req0_predDir_i), .req0_tag_i(req0_tag_i),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
    .req1_immd_i(req1_immd_i), .req1_opcode_i(req1_opcode_i),
    .req1_pc_i(req1_pc_i), .req1_predTarget_i(req1_predTarget_i),
    .req1_predDir_i(req1_predDir_i), .req1_tag_i(req1_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_nextPC_o(out_nextPC_o),
    .out_direction_o(out_direction_o), .out_flags_o(out_flags_o),
    .out_tag_o(out_tag_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .squash_valid_o(squash_valid_o), .squash_tag_o(squash_tag_o)
`ifdef CTRL_SCHED_STATS_EN
    , .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int lane, input logic [7:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [15:0] imm, input logic [31:0] pc,
                        input logic [31:0] ptgt, input logic pdir, input logic [6:0] tag);
    if (lane == 0) begin
      req0_valid_i = 1'b1; req0_opcode_i = op; req0_data1_i = d1; req0_data2_i = d2;
      req0_immd_i = imm; req0_pc_i = pc; req0_predTarget_i = ptgt;
      req0_predDir_i = pdir; req0_tag_i = tag;
    end else begin
      req1_valid_i = 1'b1; req1_opcode_i = op; req1_data1_i = d1; req1_data2_i = d2;
      req1_immd_i = imm; req1_pc_i = pc; req1_predTarget_i = ptgt;
      req1_predDir_i = pdir; req1_tag_i = tag;
    end
  endtask

  // One line per consumed result
  always @(negedge clk) begin
    if (reset_n && out_valid_o && out_ready_i) begin
      $display("out: tag=%0d nextpc=%h dir=%0b flags=%h", out_tag_o, out_nextPC_o,
               out_direction_o, out_flags_o);
      if (out_tag_o == 7'd7) seen7 <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    set_op(0, OP_BNE, 0, 0, 0, 0, 0, 1'b0, 0); req0_valid_i = 1'b0;
    set_op(1, OP_BNE, 0, 0, 0, 0, 0, 1'b0, 0); req1_valid_i = 1'b0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_redirect", 32'(redirect_valid_o), 0);
    check("rst_squash", 32'(squash_valid_o), 0);
    check("rst_out_tag", 32'(out_tag_o), 0);
    reset_n = 1'b1;
    tick();

    // Round robin: both lanes valid for 4 cycles
    set_op(0, OP_BNE, 0, 0, 0, 'h1010, 0, 1'b0, 1);
    set_op(1, OP_BNE, 0, 0, 0, 'h1020, 0, 1'b0, 2);
    #1;
    check("rr0_ready0", 32'(req0_ready_o), 1);
    check("rr0_ready1", 32'(req1_ready_o), 0);
    tick();
    set_op(0, OP_BNE, 0, 0, 0, 'h1030, 0, 1'b0, 3);
    #1;
    check("rr1_ready0", 32'(req0_ready_o), 0);
    check("rr1_ready1", 32'(req1_ready_o), 1);
    check("rr1_out_valid", 32'(out_valid_o), 0);
    tick();
    set_op(1, OP_BNE, 0, 0, 0, 'h1040, 0, 1'b0, 4);
    #1;
    check("rr2_ready0", 32'(req0_ready_o), 1);
    check("rr2_ready1", 32'(req1_ready_o), 0);
    check("rr2_out_valid", 32'(out_valid_o), 1);
    check("rr2_out_tag", 32'(out_tag_o), 1);
    check("rr2_out_nextpc", out_nextPC_o, 'h1018);
    check("rr2_out_result", out_result_o, 'h1018);
    tick();
    req0_valid_i = 1'b0;
    #1;
    check("rr3_ready1", 32'(req1_ready_o), 1);
    check("rr3_out_tag", 32'(out_tag_o), 2);
    tick();
    req1_valid_i = 1'b0;
    #1;
    check("rr4_out_tag", 32'(out_tag_o), 3);
    tick(); #1;
    check("rr5_out_tag", 32'(out_tag_o), 4);
    check("rr5_out_flags", 32'(out_flags_o), 'h02);
    tick(); #1;
    check("rr6_out_valid", 32'(out_valid_o), 0);

    // Mispredicting BEQ followed by tag 7
    set_op(0, OP_BEQ, 5, 5, 4, 'h100, 0, 1'b0, 10);
    #1;
    check("mp0_ready0", 32'(req0_ready_o), 1);
    tick();
    set_op(0, OP_BNE, 0, 0, 0, 'h2000, 0, 1'b0, 7);
    #1;
    check("mp1_ready0", 32'(req0_ready_o), 1);
    tick();
    set_op(0, OP_BNE, 0, 0, 0, 'h2010, 0, 1'b0, 8);
    #1;
    check("mp2_redirect", 32'(redirect_valid_o), 1);
    check("mp2_redirect_pc", redirect_pc_o, 'h118);
    check("mp2_squash", 32'(squash_valid_o), 1);
    check("mp2_squash_tag", 32'(squash_tag_o), 7);
    check("mp2_out_tag", 32'(out_tag_o), 10);
    check("mp2_out_flags", 32'(out_flags_o), 'h07);
    check("mp2_out_dir", 32'(out_direction_o), 1);
    check("mp2_out_nextpc", out_nextPC_o, 'h118);
    check("mp2_ready0", 32'(req0_ready_o), 0);
    tick(); #1;
    check("mp3_redirect", 32'(redirect_valid_o), 0);
    check("mp3_squash", 32'(squash_valid_o), 0);
    check("mp3_ready0", 32'(req0_ready_o), 0);
    check("mp3_out_valid", 32'(out_valid_o), 0);
    tick(); #1;
    check("mp4_ready0", 32'(req0_ready_o), 1);
    tick();
    req0_valid_i = 1'b0;
    tick(); #1;
    check("mp6_out_tag", 32'(out_tag_o), 8);
    check("mp6_tag7_seen", 32'(seen7), 0);

    // Stall with S1 and S2 full, then a stalled mispredict in S2
    tick();
    set_op(0, OP_BNE, 0, 0, 0, 'h3000, 0, 1'b0, 21);
    tick();
    set_op(0, OP_J, 0, 0, 'h10, 'h200, 0, 1'b0, 22);
    out_ready_i = 1'b0;
    #1;
    check("st1_ready0", 32'(req0_ready_o), 1);
    tick();
    set_op(0, OP_BNE, 0, 0, 0, 'h3010, 0, 1'b0, 23);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("st_ready0", 32'(req0_ready_o), 0);
      check("st_out_valid", 32'(out_valid_o), 1);
      check("st_out_tag", 32'(out_tag_o), 21);
      check("st_out_nextpc", out_nextPC_o, 'h3008);
      check("st_redirect", 32'(redirect_valid_o), 0);
      tick(); #1;
    end
    out_ready_i = 1'b1;
    #1;
    check("st5_ready0", 32'(req0_ready_o), 1);
    tick();
    req0_valid_i = 1'b0;
    out_ready_i = 1'b0;
    #1;
    check("st6_redirect", 32'(redirect_valid_o), 1);
    check("st6_redirect_pc", redirect_pc_o, 'h248);
    check("st6_squash_tag", 32'(squash_tag_o), 23);
    check("st6_out_tag", 32'(out_tag_o), 22);
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      check("st7_redirect", 32'(redirect_valid_o), 0);
      check("st7_out_tag", 32'(out_tag_o), 22);
    end
    out_ready_i = 1'b1;
    tick();

    // Flush in the cycle a mispredict would load S2
    set_op(0, OP_BEQ, 5, 5, 4, 'h100, 0, 1'b0, 30);
    #1;
    check("fl0_ready0", 32'(req0_ready_o), 1);
    tick();
    set_op(0, OP_BNE, 0, 0, 0, 'h4000, 0, 1'b0, 31);
    flush_i = 1'b1;
    #1;
    check("fl1_ready0", 32'(req0_ready_o), 0);
    tick();
    flush_i = 1'b0;
    #1;
    check("fl2_redirect", 32'(redirect_valid_o), 0);
    check("fl2_squash", 32'(squash_valid_o), 0);
    check("fl2_out_valid", 32'(out_valid_o), 0);
    check("fl2_ready0", 32'(req0_ready_o), 1);
    tick();
    req0_valid_i = 1'b0;
    tick(); #1;
    check("fl4_out_tag", 32'(out_tag_o), 31);
    tick();

    // FP branch passes through, never redirects
    set_op(0, OP_BC1T, 0, 0, 0, 'h300, 'h500, 1'b1, 12);
    tick();
    req0_valid_i = 1'b0;
    tick(); #1;
    check("fp_out_tag", 32'(out_tag_o), 12);
    check("fp_out_nextpc", out_nextPC_o, 'h500);
    check("fp_out_flags", 32'(out_flags_o), 'h16);
    check("fp_redirect", 32'(redirect_valid_o), 0);
    tick();

    // Reset in the middle of recovery
    set_op(0, OP_BEQ, 5, 5, 4, 'h100, 0, 1'b0, 40);
    tick();
    req0_valid_i = 1'b0;
    tick(); #1;
    check("rs_redirect_pre", 32'(redirect_valid_o), 1);
    reset_n = 1'b0;
    #1;
    check("rs_out_valid", 32'(out_valid_o), 0);
    check("rs_redirect", 32'(redirect_valid_o), 0);
    check("rs_redirect_pc", redirect_pc_o, 0);
    check("rs_out_tag", 32'(out_tag_o), 0);
    check("rs_out_nextpc", out_nextPC_o, 0);
    tick(); tick();
    reset_n = 1'b1;
    set_op(0, OP_BNE, 0, 0, 0, 'h5000, 0, 1'b0, 50);
    set_op(1, OP_BNE, 0, 0, 0, 'h5010, 0, 1'b0, 51);
    #1;
    check("rs_ready0", 32'(req0_ready_o), 1);
    check("rs_ready1", 32'(req1_ready_o), 0);
    tick();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick(); #1;
    check("rs_out_tag50", 32'(out_tag_o), 50);
`ifdef CTRL_SCHED_STATS_EN
    check("stat_branches", stat_branches_o, 1);
    check("stat_mispred", stat_mispred_o, 0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
